sim_run_ctrl: RTL and testbench

- Parametrised simulation run controller, instantiated between the testbench clock/reset source and riscv_top.
- Sequences CPU reset and counts run cycles against a timeout.
- Snoops CPU memory-mapped IO writes: bytes written to the TX address are captured into a character FIFO; a write to the HALT address ends the run with an exit code.
- Reports a final status and terminates cleanly. Replaces fixed-delay $finish and free-running reset handling.

---
 rtl/sim_run_pkg.sv | 23 ++
 rtl/sim_run_ctrl_if.sv | 23 ++
 rtl/sim_char_fifo.sv | 51 +++++
 rtl/sim_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sim_run_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sim_run_pkg.sv
// Shared types and constants for the simulation run controller.
package sim_run_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] DONE_NONE    = 2'd0;
  localparam logic [1:0] DONE_HALT    = 2'd1;
  localparam logic [1:0] DONE_TIMEOUT = 2'd2;

  localparam logic [31:0] DEF_TX_ADDR   = 32'h0003_0000;
  localparam logic [31:0] DEF_HALT_ADDR = 32'h0003_0004;

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// CPU IO-write snoop bus plus the character stream leaving the controller.
interface sim_run_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              io_wr_en;
  logic [ADDR_W-1:0] io_addr;
  logic [7:0]        io_wdata;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;

  modport master (
    output io_wr_en, io_addr, io_wdata, char_ready,
    input  char_valid, char_data
  );

  modport slave (
    input  io_wr_en, io_addr, io_wdata, char_ready,
    output char_valid, char_data
  );

endinterface

// File: rtl/sim_char_fifo.sv
// First-word-fall-through character FIFO with extra-bit full/empty pointers.
module sim_char_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign ovf     = push && full && !do_pop;
  assign head    = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the head is masked while empty so stale
  // entries never reach the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: CPU reset sequencing, run timeout, IO snooping.
// Optional heartbeat output enabled by defining SIM_HEARTBEAT_EN.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int                RST_CYCLES = 16,
  parameter int                CNT_W      = 32,
  parameter int                MAX_CYCLES = 150000000,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] TX_ADDR    = ADDR_W'(DEF_TX_ADDR),
  parameter logic [ADDR_W-1:0] HALT_ADDR  = ADDR_W'(DEF_HALT_ADDR),
  parameter int                FIFO_DEPTH = 16,
  parameter int                DRAIN_MAX  = 1024
`ifdef SIM_HEARTBEAT_EN
  ,
  parameter int                HEARTBEAT_PERIOD = 1000000
`endif
) (
  input  logic             clk_in,
  input  logic             rst_in,
  sim_run_ctrl_if.slave    io,
  output logic             cpu_rst_out,
  output logic             run_done,
  output logic [1:0]       done_code,
  output logic [7:0]       exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic             fifo_ovf
`ifdef SIM_HEARTBEAT_EN
  ,
  output logic             heartbeat
`endif
);

  localparam int HOLD_W  = cnt_bits(RST_CYCLES);
  localparam int DRAIN_W = cnt_bits(DRAIN_MAX);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0]   LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

  state_t               state;
  state_t               next_state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;

  logic is_tx;
  logic is_halt;
  logic tx_push;
  logic halt_hit;
  logic timeout_hit;
  logic drain_expire;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_ovf_pulse;

  assign is_tx   = io.io_wr_en && (io.io_addr == TX_ADDR);
  assign is_halt = io.io_wr_en && (io.io_addr == HALT_ADDR);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= HOLD;
    else        state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    next_state   = state;
    tx_push      = 1'b0;
    halt_hit     = 1'b0;
    timeout_hit  = 1'b0;
    drain_expire = 1'b0;
    unique case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) next_state = RUN;
      end
      RUN: begin
        tx_push = is_tx;
        // Halt has priority over a timeout landing in the same cycle.
        if (is_halt) begin
          halt_hit   = 1'b1;
          next_state = DRAIN;
        end else if (cycle_count == LAST_CYCLE) begin
          timeout_hit = 1'b1;
          next_state  = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          next_state = DONE;
        end else if (drain_cnt == DRAIN_LAST) begin
          drain_expire = 1'b1;
          next_state   = DONE;
        end
      end
      DONE: ;
      default: next_state = HOLD;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      cycle_count <= '0;
      done_code   <= DONE_NONE;
      exit_code   <= '0;
      fifo_ovf    <= 1'b0;
    end else begin
      if (state == HOLD)  hold_cnt    <= hold_cnt + 1'b1;
      if (state == RUN)   cycle_count <= cycle_count + 1'b1;
      if (state == DRAIN) drain_cnt   <= drain_cnt + 1'b1;
      if (halt_hit) begin
        exit_code <= io.io_wdata;
        done_code <= DONE_HALT;
      end
      if (timeout_hit) done_code <= DONE_TIMEOUT;
      if (fifo_ovf_pulse || drain_expire) fifo_ovf <= 1'b1;
    end
  end

  assign cpu_rst_out = (state == HOLD) || (state == DONE);
  assign run_done    = (state == DONE);

  sim_char_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .flush     (drain_expire),
    .push      (tx_push),
    .push_data (io.io_wdata),
    .pop       (io.char_ready),
    .head      (io.char_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf       (fifo_ovf_pulse)
  );

  assign io.char_valid = !fifo_empty;

  a_full_not_empty : assert property (@(posedge clk_in) disable iff (rst_in)
    fifo_full |-> !fifo_empty);

`ifdef SIM_HEARTBEAT_EN
  localparam int                HB_W    = cnt_bits(HEARTBEAT_PERIOD);
  localparam logic [HB_W-1:0]   HB_LAST = HB_W'(HEARTBEAT_PERIOD - 1);

  // Tracks cycle_count modulo the period without a divider.
  logic [HB_W-1:0] hb_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hb_cnt <= '0;
    end else if (state == RUN) begin
      hb_cnt <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + 1'b1;
    end
  end

  assign heartbeat = (state == RUN) && (hb_cnt == HB_LAST);
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Table-driven bench for sim_run_ctrl; heartbeat checks follow SIM_HEARTBEAT_EN.
module tb_sim_run_ctrl;

  localparam logic [31:0] TX   = 32'h0003_0000;
  localparam logic [31:0] HALT = 32'h0003_0004;

  typedef struct {
    string       lbl;
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic        rdy;
    logic        e_cpu;
    logic        e_v;
    logic [7:0]  e_d;
    logic        e_done;
    logic [1:0]  e_code;
    logic [7:0]  e_exit;
    logic [31:0] e_cnt;
    logic        e_ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rst_out;
  logic        run_done;
  logic [1:0]  done_code;
  logic [7:0]  exit_code;
  logic [31:0] cycle_count;
  logic        fifo_ovf;
  logic        hb_act;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  sim_run_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef SIM_HEARTBEAT_EN
  logic heartbeat;
  assign hb_act = heartbeat;
`else
  assign hb_act = 1'b0;
`endif

  sim_run_ctrl #(
    .RST_CYCLES (16),
    .CNT_W      (32),
    .MAX_CYCLES (100),
    .ADDR_W     (32),
    .TX_ADDR    (TX),
    .HALT_ADDR  (HALT),
    .FIFO_DEPTH (4),
    .DRAIN_MAX  (8)
`ifdef SIM_HEARTBEAT_EN
    ,
    .HEARTBEAT_PERIOD (10)
`endif
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .io          (bus),
    .cpu_rst_out (cpu_rst_out),
    .run_done    (run_done),
    .done_code   (done_code),
    .exit_code   (exit_code),
    .cycle_count (cycle_count),
    .fifo_ovf    (fifo_ovf)
`ifdef SIM_HEARTBEAT_EN
    ,
    .heartbeat   (heartbeat)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void add(input string lbl, input logic r, input logic wr,
                              input logic [31:0] addr, input logic [7:0] wd, input logic rdy,
                              input logic e_cpu, input logic e_v, input logic [7:0] e_d,
                              input logic e_done, input logic [1:0] e_code,
                              input logic [7:0] e_exit, input logic [31:0] e_cnt,
                              input logic e_ovf);
    vec_t v;
    v.lbl = lbl; v.rst = r; v.wr = wr; v.addr = addr; v.wd = wd; v.rdy = rdy;
    v.e_cpu = e_cpu; v.e_v = e_v; v.e_d = e_d; v.e_done = e_done;
    v.e_code = e_code; v.e_exit = e_exit; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    vq.push_back(v);
  endfunction

  // One reset cycle, then 16 HOLD cycles; the 16th edge enters RUN.
  function automatic void add_reset_hold(input string lbl);
    add({lbl, "_rst"}, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 2'd0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++)
      add({lbl, "_hold"}, 0, 0, 0, 0, 0, (i < 15), 0, 8'h00, 0, 2'd0, 8'h00, 0, 0);
  endfunction

  function automatic void add_idle(input string lbl, input int n, input int start);
    for (int j = 1; j <= n; j++)
      add(lbl, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 2'd0, 8'h00, 32'(start + j), 0);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    logic [54:0] act;
    logic [54:0] exp;
    logic        e_hb;
    rst          = v.rst;
    bus.io_wr_en = v.wr;
    bus.io_addr  = v.addr;
    bus.io_wdata = v.wd;
    bus.char_ready = v.rdy;
    @(posedge clk);
    #1;
`ifdef SIM_HEARTBEAT_EN
    e_hb = !v.e_cpu && (v.e_code == 2'd0) && (((v.e_cnt + 32'd1) % 32'd10) == 32'd0);
`else
    e_hb = 1'b0;
`endif
    act = {cpu_rst_out, bus.char_valid, bus.char_data, run_done, done_code,
           exit_code, cycle_count, fifo_ovf, hb_act};
    exp = {v.e_cpu, v.e_v, v.e_d, v.e_done, v.e_code, v.e_exit, v.e_cnt, v.e_ovf, e_hb};
    check($sformatf("vec%0d_%s{cpu,v,d,done,code,exit,cnt,ovf,hb}", idx, v.lbl),
          64'(act), 64'(exp));
  endtask

  initial begin
    int edges;
    rst            = 1'b1;
    bus.io_wr_en   = 1'b0;
    bus.io_addr    = '0;
    bus.io_wdata   = '0;
    bus.char_ready = 1'b0;

    // Power-up reset, then HOLD with IO writes that must be ignored.
    for (int i = 0; i < 3; i++)
      add("por", 1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 2'd0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++)
      add("hold_io", 0, (i == 5 || i == 7), (i == 5) ? TX : HALT, 8'hAA, 0,
          (i < 15), 0, 8'h00, 0, 2'd0, 8'h00, 0, 0);

    // "Hi" then halt with code 5; drain pops both bytes before DONE.
    add("tx_H",      0, 1, TX,   8'h48, 0, 0, 1, 8'h48, 0, 2'd0, 8'h00, 1, 0);
    add("tx_i",      0, 1, TX,   8'h69, 0, 0, 1, 8'h48, 0, 2'd0, 8'h00, 2, 0);
    add("halt",      0, 1, HALT, 8'h05, 0, 0, 1, 8'h48, 0, 2'd1, 8'h05, 3, 0);
    add("drain1",    0, 0, 0,    8'h00, 1, 0, 1, 8'h69, 0, 2'd1, 8'h05, 3, 0);
    add("drain2",    0, 0, 0,    8'h00, 1, 0, 0, 8'h00, 0, 2'd1, 8'h05, 3, 0);
    add("done",      0, 0, 0,    8'h00, 1, 1, 0, 8'h00, 1, 2'd1, 8'h05, 3, 0);
    add("done_halt", 0, 1, HALT, 8'h77, 1, 1, 0, 8'h00, 1, 2'd1, 8'h05, 3, 0);
    add("done_tx",   0, 1, TX,   8'h12, 1, 1, 0, 8'h00, 1, 2'd1, 8'h05, 3, 0);

    // Overflow: depth 4, six pushes with no consumer, then a drain timeout.
    add_reset_hold("ovf");
    add("other_addr", 0, 1, 32'h0003_0008, 8'h11, 0, 0, 0, 8'h00, 0, 2'd0, 8'h00, 1, 0);
    for (int b = 1; b <= 6; b++)
      add("fill", 0, 1, TX, 8'(b), 0, 0, 1, 8'h01, 0, 2'd0, 8'h00, 32'(1 + b), (b >= 5));
    add("push_full_pop", 0, 1, TX,   8'h07, 1, 0, 1, 8'h02, 0, 2'd0, 8'h00, 8, 1);
    add("halt_ovf",      0, 1, HALT, 8'h3C, 0, 0, 1, 8'h02, 0, 2'd1, 8'h3C, 9, 1);
    for (int k = 1; k <= 7; k++)
      add("drain_stall", 0, 0, 0, 8'h00, 0, 0, 1, 8'h02, 0, 2'd1, 8'h3C, 9, 1);
    add("drain_expire",  0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 2'd1, 8'h3C, 9, 1);
    add("done_flushed",  0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 2'd1, 8'h3C, 9, 1);

    // Plain timeout at MAX_CYCLES=100.
    add_reset_hold("tmo");
    add_idle("tmo_run", 99, 0);
    add("timeout",      0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 2'd2, 8'h00, 100, 0);
    add("timeout_done", 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 1, 2'd2, 8'h00, 100, 0);
    add("timeout_hold", 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 1, 2'd2, 8'h00, 100, 0);

    // Halt in the last cycle beats the timeout.
    add_reset_hold("hvt");
    add_idle("hvt_run", 99, 0);
    add("halt_at_last", 0, 1, HALT, 8'hA5, 0, 0, 0, 8'h00, 0, 2'd1, 8'hA5, 100, 0);
    add("hvt_done",     0, 0, 0,    8'h00, 0, 1, 0, 8'h00, 1, 2'd1, 8'hA5, 100, 0);

    // Push+pop on empty (no bypass), then a TX write in the timeout cycle.
    add_reset_hold("txt");
    add("pushpop_empty", 0, 1, TX, 8'h77, 1, 0, 1, 8'h77, 0, 2'd0, 8'h00, 1, 0);
    add("pop_77",        0, 0, 0,  8'h00, 1, 0, 0, 8'h00, 0, 2'd0, 8'h00, 2, 0);
    add_idle("txt_run", 97, 2);
    add("tx_at_timeout", 0, 1, TX, 8'h5A, 0, 0, 1, 8'h5A, 0, 2'd2, 8'h00, 100, 0);
    add("drain_pop",     0, 0, 0,  8'h00, 1, 0, 0, 8'h00, 0, 2'd2, 8'h00, 100, 0);
    add("drain_done",    0, 0, 0,  8'h00, 1, 1, 0, 8'h00, 1, 2'd2, 8'h00, 100, 0);

    // Reset pulsed mid-RUN clears everything and restarts HOLD.
    add_reset_hold("mid");
    add("run_tx",     0, 1, TX, 8'h9C, 0, 0, 1, 8'h9C, 0, 2'd0, 8'h00, 1, 0);
    add("mid_rst",    1, 0, 0,  8'h00, 0, 1, 0, 8'h00, 0, 2'd0, 8'h00, 0, 0);
    add("hold_again", 0, 0, 0,  8'h00, 0, 1, 0, 8'h00, 0, 2'd0, 8'h00, 0, 0);

    foreach (vq[i]) apply(i, vq[i]);

    // Hand-written: count edges from rst_in falling to cpu_rst_out falling.
    rst          = 1'b1;
    bus.io_wr_en = 1'b0;
    bus.char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    edges = 0;
    while (edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (!cpu_rst_out) break;
    end
    check("release_edges", 64'(edges), 64'd16);
    check("release_count", 64'(cycle_count), 64'd0);
    check("release_not_done", 64'(run_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
